bus_dma: RTL and testbench

Single-channel word-copy DMA engine for the RV1 SoC. It is an initiator on the SoC data bus, arbitrated in front of the bus master port alongside the core. It is also a responder for its own configuration registers, decoded like CLINT with a 16-bit offset. Software programs source, destination and length, then writes START. The engine alternates one 32-bit read and one 32-bit write per word until the length is exhausted, then raises DONE and an optional level interrupt.

---
 rtl/bus_dma_pkg.sv | 30 +++
 rtl/bus_dma_regs.sv | 83 ++++++++
 rtl/bus_dma.sv | 151 +++++++++++++++
 tb/tb_bus_dma.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dma_pkg.sv
// Shared definitions for the single-channel word-copy DMA engine:
// register map, CTRL/STATUS bit positions and FSM state encoding.
package bus_dma_pkg;

  // Register select, taken from cfg_req_addr[5:3]
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_REMAIN = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_ABORT = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_ABORTED = 3;

  localparam logic [2:0] DMA_SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/bus_dma_regs.sv
// Configuration register file: address decode, W1C status with set priority,
// START/ABORT pulse generation and the combinational read mux.
module bus_dma_regs
  import bus_dma_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_req_valid,
  input  logic [15:0]     cfg_req_addr,
  input  logic [63:0]     cfg_req_wdata,
  input  logic            cfg_req_we,
  output logic            cfg_req_ready,
  output logic [63:0]     cfg_req_rdata,
  input  logic            busy,
  input  logic            set_done,
  input  logic            set_err,
  input  logic            set_aborted,
  input  logic [XLEN-1:0] remain,
  output logic [XLEN-1:0] src,
  output logic [XLEN-1:0] dst,
  output logic [XLEN-1:0] len,
  output logic            ie,
  output logic            done,
  output logic            err,
  output logic            aborted,
  output logic            start_pulse,
  output logic            abort_pulse
);

  logic       hit;
  logic       wr;
  logic [2:0] sel;
  logic       wr_stat;
  logic       unused_bits;

  assign hit           = (cfg_req_addr[15:6] == '0);
  assign sel           = cfg_req_addr[5:3];
  assign wr            = cfg_req_valid && cfg_req_we && hit;
  assign wr_stat       = wr && (sel == REG_STATUS);
  assign start_pulse   = wr && (sel == REG_CTRL) && cfg_req_wdata[CTRL_START];
  assign abort_pulse   = wr && (sel == REG_CTRL) && cfg_req_wdata[CTRL_ABORT];
  assign cfg_req_ready = cfg_req_valid;
  assign unused_bits   = ^{cfg_req_wdata, cfg_req_addr[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      ie      <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
    end else begin
      if (wr && !busy && sel == REG_SRC) src <= cfg_req_wdata[XLEN-1:0];
      if (wr && !busy && sel == REG_DST) dst <= cfg_req_wdata[XLEN-1:0];
      if (wr && !busy && sel == REG_LEN) len <= cfg_req_wdata[XLEN-1:0];
      if (wr && sel == REG_CTRL) ie <= cfg_req_wdata[CTRL_IE];
      // A hardware set in the same cycle as a software clear keeps the bit set
      done    <= set_done    | (done    & ~(wr_stat & cfg_req_wdata[STAT_DONE]));
      err     <= set_err     | (err     & ~(wr_stat & cfg_req_wdata[STAT_ERR]));
      aborted <= set_aborted | (aborted & ~(wr_stat & cfg_req_wdata[STAT_ABORTED]));
    end
  end

  always_comb begin
    cfg_req_rdata = '0;
    if (hit) begin
      case (sel)
        REG_SRC:    cfg_req_rdata[XLEN-1:0] = src;
        REG_DST:    cfg_req_rdata[XLEN-1:0] = dst;
        REG_LEN:    cfg_req_rdata[XLEN-1:0] = len;
        REG_CTRL:   cfg_req_rdata[CTRL_IE]  = ie;
        REG_STATUS: cfg_req_rdata[3:0]      = {aborted, err, done, busy};
        REG_REMAIN: cfg_req_rdata[XLEN-1:0] = remain;
        default:    cfg_req_rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/bus_dma.sv
// Single-channel word-copy DMA: alternates one word read and one word write
// on the bus master port until the programmed length is exhausted.
//   state    | meaning
//   ST_IDLE  | no bus request; waits for START
//   ST_READ  | reading word at src pointer; abort drops the request
//   ST_WRITE | writing buffered word to dst pointer; held until accepted
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_req_valid,
  input  logic [15:0]     cfg_req_addr,
  input  logic [63:0]     cfg_req_wdata,
  input  logic            cfg_req_we,
  output logic            cfg_req_ready,
  output logic [63:0]     cfg_req_rdata,
  output logic            dma_req_valid,
  output logic [XLEN-1:0] dma_req_addr,
  output logic [63:0]     dma_req_wdata,
  output logic            dma_req_we,
  output logic [2:0]      dma_req_size,
  input  logic            dma_req_ready,
  input  logic [63:0]     dma_req_rdata,
  output logic            irq
);

  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

  state_t          state;
  logic [XLEN-1:0] src, dst, len;
  logic [XLEN-1:0] src_ptr, dst_ptr, remain;
  logic [31:0]     buf_q;
  logic            abort_pend;
  logic            ie, done, err, aborted;
  logic            start_pulse, abort_pulse;
  logic            busy, abort_any, start_err, len_zero, last_word, wr_accept;
  logic            set_done, set_err, set_aborted;
  logic            unused_bits;

  bus_dma_regs #(.XLEN(XLEN)) u_regs (
    .clk          (clk),
    .reset        (reset),
    .cfg_req_valid(cfg_req_valid),
    .cfg_req_addr (cfg_req_addr),
    .cfg_req_wdata(cfg_req_wdata),
    .cfg_req_we   (cfg_req_we),
    .cfg_req_ready(cfg_req_ready),
    .cfg_req_rdata(cfg_req_rdata),
    .busy         (busy),
    .set_done     (set_done),
    .set_err      (set_err),
    .set_aborted  (set_aborted),
    .remain       (remain),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .ie           (ie),
    .done         (done),
    .err          (err),
    .aborted      (aborted),
    .start_pulse  (start_pulse),
    .abort_pulse  (abort_pulse)
  );

  assign busy      = (state != ST_IDLE);
  assign abort_any = abort_pulse || abort_pend;
  assign start_err = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
  assign len_zero  = (len[XLEN-1:2] == '0);
  assign last_word = (remain == WORD_BYTES);
  assign wr_accept = (state == ST_WRITE) && dma_req_ready;

  assign set_err     = (state == ST_IDLE) && start_pulse && start_err;
  assign set_done    = ((state == ST_IDLE) && start_pulse && !start_err && len_zero) ||
                       (wr_accept && !abort_any && last_word);
  assign set_aborted = ((state == ST_READ) && abort_any) || (wr_accept && abort_any);

  assign dma_req_wdata = {32'h0, buf_q};
  assign dma_req_size  = DMA_SIZE_WORD;
  assign irq           = done && ie;
  assign unused_bits   = ^{dma_req_rdata[63:32], len[1:0], err, aborted};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      src_ptr       <= '0;
      dst_ptr       <= '0;
      remain        <= '0;
      buf_q         <= '0;
      abort_pend    <= 1'b0;
      dma_req_valid <= 1'b0;
      dma_req_we    <= 1'b0;
      dma_req_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          abort_pend <= 1'b0;
          if (start_pulse && !start_err && !len_zero) begin
            src_ptr       <= src;
            dst_ptr       <= dst;
            remain        <= {len[XLEN-1:2], 2'b00};
            dma_req_valid <= 1'b1;
            dma_req_we    <= 1'b0;
            dma_req_addr  <= src;
            state         <= ST_READ;
          end
        end
        ST_READ: begin
          if (abort_any) begin
            abort_pend    <= 1'b0;
            dma_req_valid <= 1'b0;
            dma_req_addr  <= '0;
            state         <= ST_IDLE;
          end else if (dma_req_ready) begin
            buf_q        <= dma_req_rdata[31:0];
            src_ptr      <= src_ptr + WORD_BYTES;
            dma_req_we   <= 1'b1;
            dma_req_addr <= dst_ptr;
            state        <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (abort_pulse) abort_pend <= 1'b1;
          if (dma_req_ready) begin
            dst_ptr <= dst_ptr + WORD_BYTES;
            remain  <= remain - WORD_BYTES;
            if (abort_any || last_word) begin
              abort_pend    <= 1'b0;
              dma_req_valid <= 1'b0;
              dma_req_we    <= 1'b0;
              dma_req_addr  <= '0;
              state         <= ST_IDLE;
            end else begin
              dma_req_we   <= 1'b0;
              dma_req_addr <= src_ptr;
              state        <= ST_READ;
            end
          end
        end
        default: begin
          dma_req_valid <= 1'b0;
          dma_req_we    <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: word-memory responder with optional stalls,
// request-stability monitor and hand-computed expected values.
module tb_bus_dma;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_req_valid, cfg_req_we, cfg_req_ready;
  logic [15:0]     cfg_req_addr;
  logic [63:0]     cfg_req_wdata, cfg_req_rdata;
  logic            dma_req_valid, dma_req_we;
  logic [XLEN-1:0] dma_req_addr;
  logic [63:0]     dma_req_wdata, dma_req_rdata;
  logic [2:0]      dma_req_size;
  logic            dma_req_ready = 1'b1;
  logic            irq;

  logic [31:0]     mem [0:127];
  int              n_checks = 0, n_errors = 0;
  int              n_rd = 0, n_wr = 0, req_idx = 0, stall_cnt = 0;
  logic            exp_we = 1'b0, acc_q = 1'b0, in_req = 1'b0;
  logic            stall_mode = 1'b0, hold_low = 1'b0;
  logic [XLEN-1:0] held_addr = '0;
  logic [32:0]     held_wd = '0;

  always #5 clk = ~clk;

  bus_dma #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_req_valid(cfg_req_valid),
    .cfg_req_addr (cfg_req_addr),
    .cfg_req_wdata(cfg_req_wdata),
    .cfg_req_we   (cfg_req_we),
    .cfg_req_ready(cfg_req_ready),
    .cfg_req_rdata(cfg_req_rdata),
    .dma_req_valid(dma_req_valid),
    .dma_req_addr (dma_req_addr),
    .dma_req_wdata(dma_req_wdata),
    .dma_req_we   (dma_req_we),
    .dma_req_size (dma_req_size),
    .dma_req_ready(dma_req_ready),
    .dma_req_rdata(dma_req_rdata),
    .irq          (irq)
  );

  // memory window 0x8000_0000..0x8000_01FF; everything else reads 0
  assign dma_req_rdata = (dma_req_addr[31:9] == 23'h400000) ?
                         {32'h0, mem[dma_req_addr[8:2]]} : 64'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    acc_q = dma_req_valid && dma_req_ready;
    if (acc_q) begin
      chk("alt_we", 64'(dma_req_we), 64'(exp_we));
      exp_we = ~exp_we;
      if (dma_req_we) begin
        n_wr++;
        if (dma_req_addr[31:9] == 23'h400000) mem[dma_req_addr[8:2]] = dma_req_wdata[31:0];
      end else begin
        n_rd++;
      end
    end
  end

  always @(negedge clk) begin
    if (!dma_req_valid || acc_q) in_req = 1'b0;
    if (in_req && dma_req_valid) begin
      chk("hold_addr", 64'(dma_req_addr), 64'(held_addr));
      chk("hold_we_wdata", 64'({dma_req_we, dma_req_wdata[31:0]}), 64'(held_wd));
      if (stall_cnt > 0) stall_cnt--;
    end else if (dma_req_valid) begin
      in_req    = 1'b1;
      req_idx++;
      held_addr = dma_req_addr;
      held_wd   = {dma_req_we, dma_req_wdata[31:0]};
      stall_cnt = (stall_mode && (req_idx % 2 == 0)) ? 3 : 0;
    end
    dma_req_ready = (stall_cnt == 0) && !(hold_low && dma_req_we);
  end

  task automatic cfg_write(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    cfg_req_valid = 1'b1;
    cfg_req_we    = 1'b1;
    cfg_req_addr  = a;
    cfg_req_wdata = d;
    @(posedge clk);
    #1;
    cfg_req_valid = 1'b0;
    cfg_req_we    = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [63:0] d);
    cfg_req_valid = 1'b1;
    cfg_req_we    = 1'b0;
    cfg_req_addr  = a;
    #1;
    d = cfg_req_rdata;
    cfg_req_valid = 1'b0;
  endtask

  // cyc = 1 is the cycle right after the START edge
  task automatic wait_status(input int bit_i, input logic val, output int cyc);
    logic [63:0] st;
    cyc = 1;
    peek(16'h20, st);
    while (st[bit_i] !== val && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      peek(16'h20, st);
    end
  endtask

  task automatic new_xfer();
    for (int i = 64; i < 68; i++) mem[i] = 32'h0;
    n_rd   = 0;
    n_wr   = 0;
    exp_we = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [63:0] rd;

    reset = 1'b1;
    cfg_req_valid = 1'b0;
    cfg_req_we    = 1'b0;
    cfg_req_addr  = '0;
    cfg_req_wdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid", 64'(dma_req_valid), 64'd0);
    chk("rst_we", 64'(dma_req_we), 64'd0);
    chk("rst_addr", 64'(dma_req_addr), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    peek(16'h20, rd); chk("rst_status", rd, 64'd0);
    peek(16'h00, rd); chk("rst_src", rd, 64'd0);

    // 16-byte copy, ready always high: DONE in cycle N+9
    new_xfer();
    cfg_write(16'h00, 64'h8000_0000);
    cfg_write(16'h08, 64'h8000_0100);
    cfg_write(16'h10, 64'd16);
    cfg_write(16'h18, 64'h3);
    chk("t1_busy_at_n1", 64'(dma_req_valid), 64'd1);
    wait_status(1, 1'b1, cyc);
    chk("t1_done_cycle", 64'(cyc), 64'd9);
    chk("t1_reads", 64'(n_rd), 64'd4);
    chk("t1_writes", 64'(n_wr), 64'd4);
    for (int i = 0; i < 4; i++) chk("t1_data", 64'(mem[64+i]), 64'(32'hA5A5_0000 + 32'(i)));
    chk("t1_irq", 64'(irq), 64'd1);
    peek(16'h20, rd); chk("t1_status", rd, 64'h2);
    peek(16'h28, rd); chk("t1_remain", rd, 64'd0);
    cfg_write(16'h20, 64'h2);
    chk("t1_irq_clr", 64'(irq), 64'd0);

    // same copy with every write stalled 3 cycles: 4*1 + 4*4 cycles, DONE in N+21
    new_xfer();
    req_idx    = 0;
    stall_mode = 1'b1;
    cfg_write(16'h18, 64'h3);
    wait_status(1, 1'b1, cyc);
    stall_mode = 1'b0;
    chk("t2_done_cycle", 64'(cyc), 64'd21);
    for (int i = 0; i < 4; i++) chk("t2_data", 64'(mem[64+i]), 64'(32'hA5A5_0000 + 32'(i)));
    cfg_write(16'h20, 64'h2);

    // LEN = 0 and LEN = 3 both complete at once without bus traffic
    n_rd = 0;
    n_wr = 0;
    cfg_write(16'h10, 64'd0);
    cfg_write(16'h18, 64'h3);
    wait_status(1, 1'b1, cyc);
    chk("t3_len0_cycle", 64'(cyc), 64'd1);
    peek(16'h20, rd); chk("t3_len0_status", rd, 64'h2);
    cfg_write(16'h20, 64'h2);
    cfg_write(16'h10, 64'd3);
    cfg_write(16'h18, 64'h3);
    peek(16'h20, rd); chk("t3_len3_status", rd, 64'h2);
    chk("t3_no_req", 64'(n_rd + n_wr), 64'd0);
    cfg_write(16'h20, 64'h2);

    // misaligned source raises ERR and issues no request
    cfg_write(16'h00, 64'h8000_0002);
    cfg_write(16'h10, 64'd16);
    cfg_write(16'h18, 64'h3);
    peek(16'h20, rd); chk("t4_err_status", rd, 64'h4);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_req", 64'(n_rd + n_wr), 64'd0);
    chk("t4_valid", 64'(dma_req_valid), 64'd0);
    cfg_write(16'h20, 64'h4);

    // abort during a stalled second write: the write lands, REMAIN = 16 - 8
    new_xfer();
    cfg_write(16'h00, 64'h8000_0000);
    cfg_write(16'h18, 64'h3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hold_low = 1'b1;
    @(posedge clk); #1;
    cfg_write(16'h18, 64'h6);
    chk("t5_held_valid", 64'(dma_req_valid), 64'd1);
    chk("t5_held_we", 64'(dma_req_we), 64'd1);
    chk("t5_held_addr", 64'(dma_req_addr), 64'h8000_0104);
    peek(16'h20, rd); chk("t5_busy", rd, 64'h1);
    hold_low = 1'b0;
    wait_status(0, 1'b0, cyc);
    peek(16'h20, rd); chk("t5_status", rd, 64'h8);
    peek(16'h28, rd); chk("t5_remain", rd, 64'd8);
    chk("t5_writes", 64'(n_wr), 64'd2);
    chk("t5_word1", 64'(mem[65]), 64'hA5A5_0001);
    chk("t5_word2", 64'(mem[66]), 64'h0);
    cfg_write(16'h20, 64'h8);

    // SRC write and re-START while busy are ignored; W1C at completion loses
    new_xfer();
    cfg_write(16'h18, 64'h3);
    cfg_write(16'h00, 64'h8000_0040);
    cfg_write(16'h18, 64'h3);
    cyc = 0;
    peek(16'h28, rd);
    while (!(dma_req_valid && dma_req_we && rd == 64'd4) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      peek(16'h28, rd);
    end
    chk("t6_last_write_seen", 64'(cyc < 100), 64'd1);
    cfg_write(16'h20, 64'h2);
    peek(16'h20, rd); chk("t6_status", rd, 64'h2);
    peek(16'h00, rd); chk("t6_src_kept", rd, 64'h8000_0000);
    chk("t6_reads", 64'(n_rd), 64'd4);
    chk("t6_writes", 64'(n_wr), 64'd4);
    for (int i = 0; i < 4; i++) chk("t6_data", 64'(mem[64+i]), 64'(32'hA5A5_0000 + 32'(i)));
    cfg_write(16'h20, 64'h2);

    // reset while a READ is outstanding
    cfg_write(16'h18, 64'h3);
    chk("t7_pre_valid", 64'(dma_req_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t7_valid", 64'(dma_req_valid), 64'd0);
    chk("t7_we", 64'(dma_req_we), 64'd0);
    chk("t7_addr", 64'(dma_req_addr), 64'd0);
    chk("t7_irq", 64'(irq), 64'd0);
    for (int i = 0; i < 6; i++) begin
      peek(16'(i * 8), rd);
      chk("t7_reg", rd, 64'd0);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
